qcontrol_delay_gain: RTL and testbench

- Generates the Q-control feedback signal for the volume/Q-control mixer stage, which sums it with the excitation volume signal.
- Takes the demodulated/ADC signal stream, applies a programmable sample delay (phase shift) through a circular buffer, then a signed Q22 gain with rounding and saturation.
- Emits the 16-bit Q-control sample stream consumed on the mixer's QS input.

---
 rtl/qcontrol_delay_gain.sv | 149 ++++++++++++++
 tb/tb_qcontrol_delay_gain.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/qcontrol_delay_gain.sv
// Q-control feedback path: programmable sample delay through a circular
// buffer, then a signed Q-format gain with round-half-up and saturation.
// Three register stages from input strobe to output strobe.
module qcontrol_delay_gain #(
   parameter int SIGNAL_WIDTH     = 16,
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int QS_WIDTH         = 16,
   parameter int GAIN_WIDTH       = 32,
   parameter int GAIN_Q           = 22,
   parameter int DELAY_ADDR_WIDTH = 10
) (
   input  logic                          a_clk,
   input  logic                          a_resetn,
   input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_SIGNAL_tdata,
   input  logic                          S_AXIS_SIGNAL_tvalid,
   input  logic                          qc_enable,
   input  logic [DELAY_ADDR_WIDTH-1:0]   qc_delay,
   input  logic signed [GAIN_WIDTH-1:0]  qc_gain,
   output logic signed [QS_WIDTH-1:0]    M_AXIS_QS_tdata,
   output logic                          M_AXIS_QS_tvalid,
   output logic                          qc_sat
);

   localparam int DEPTH  = 1 << DELAY_ADDR_WIDTH;
   localparam int PROD_W = SIGNAL_WIDTH + GAIN_WIDTH;

   localparam logic [DELAY_ADDR_WIDTH-1:0] FILL_MAX = '1;
   localparam logic signed [PROD_W-1:0] ROUND  = {{(PROD_W-1){1'b0}}, 1'b1} << (GAIN_Q - 1);
   localparam logic signed [PROD_W-1:0] QS_MAX = PROD_W'(signed'((2 ** (QS_WIDTH - 1)) - 1));
   localparam logic signed [PROD_W-1:0] QS_MIN = -QS_MAX - 1;

   // Delay line storage; never reset, stale words are masked by fill_cnt.
   logic signed [SIGNAL_WIDTH-1:0] ram [DEPTH];
   logic signed [SIGNAL_WIDTH-1:0] ram_q;

   logic signed [SIGNAL_WIDTH-1:0] sample;
   logic [DELAY_ADDR_WIDTH-1:0]    wr_ptr;
   logic [DELAY_ADDR_WIDTH-1:0]    fill_cnt;
   logic [DELAY_ADDR_WIDTH-1:0]    rd_addr;
   logic                           tap_ok;
   logic                           unused_low;

   // Stage 1 registers (gain is latched here, applying to this very sample).
   logic                           s1_valid;
   logic                           s1_ok;
   logic                           s1_fwd;
   logic signed [SIGNAL_WIDTH-1:0] s1_x;
   logic signed [GAIN_WIDTH-1:0]   s1_gain;
   logic signed [SIGNAL_WIDTH-1:0] tap;

   // Stage 2 registers.
   logic                           s2_valid;
   logic                           s2_ok;
   logic signed [PROD_W-1:0]       s2_prod;

   // Stage 3 combinational result.
   logic signed [PROD_W-1:0]       rounded;
   logic signed [QS_WIDTH-1:0]     qs_next;
   logic                           sat_next;

   assign sample     = S_AXIS_SIGNAL_tdata[AXIS_TDATA_WIDTH-1 -: SIGNAL_WIDTH];
   assign unused_low = ^S_AXIS_SIGNAL_tdata[AXIS_TDATA_WIDTH-SIGNAL_WIDTH-1:0];
   assign rd_addr    = wr_ptr - qc_delay;
   assign tap_ok     = (fill_cnt >= qc_delay);
   // d = 0 takes the sample straight from the input, bypassing the RAM.
   assign tap        = s1_fwd ? s1_x : ram_q;

   // Circular buffer write and registered read of the delayed tap.
   always_ff @(posedge a_clk) begin
      if (S_AXIS_SIGNAL_tvalid) begin
         ram[wr_ptr] <= sample;
         ram_q       <= ram[rd_addr];
      end
   end

   // Stage 1: pointer, fill history and per-sample control capture.
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         wr_ptr   <= '0;
         fill_cnt <= '0;
         s1_valid <= 1'b0;
         s1_ok    <= 1'b0;
         s1_fwd   <= 1'b0;
         s1_x     <= '0;
         s1_gain  <= '0;
      end else begin
         s1_valid <= S_AXIS_SIGNAL_tvalid;
         if (!qc_enable) begin
            fill_cnt <= '0;
         end else if (S_AXIS_SIGNAL_tvalid && (fill_cnt != FILL_MAX)) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
         if (S_AXIS_SIGNAL_tvalid) begin
            wr_ptr  <= wr_ptr + 1'b1;
            s1_ok   <= tap_ok && qc_enable;
            s1_fwd  <= (qc_delay == '0);
            s1_x    <= sample;
            s1_gain <= qc_gain;
         end
      end
   end

   // Stage 2: full-width signed product.
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         s2_valid <= 1'b0;
         s2_ok    <= 1'b0;
         s2_prod  <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_ok   <= s1_ok;
            s2_prod <= PROD_W'(tap) * PROD_W'(s1_gain);
         end
      end
   end

   // Round half toward +inf, arithmetic shift, clamp; masked samples give 0.
   always_comb begin
      rounded  = (s2_prod + ROUND) >>> GAIN_Q;
      qs_next  = rounded[QS_WIDTH-1:0];
      sat_next = 1'b0;
      if (!s2_ok) begin
         qs_next = '0;
      end else if (rounded > QS_MAX) begin
         qs_next  = QS_MAX[QS_WIDTH-1:0];
         sat_next = 1'b1;
      end else if (rounded < QS_MIN) begin
         qs_next  = QS_MIN[QS_WIDTH-1:0];
         sat_next = 1'b1;
      end
   end

   // Stage 3: output registers; data and saturation flag hold between strobes.
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         M_AXIS_QS_tvalid <= 1'b0;
         M_AXIS_QS_tdata  <= '0;
         qc_sat           <= 1'b0;
      end else begin
         M_AXIS_QS_tvalid <= s2_valid;
         if (s2_valid) begin
            M_AXIS_QS_tdata <= qs_next;
            qc_sat          <= sat_next;
         end
      end
   end

endmodule

// File: tb/tb_qcontrol_delay_gain.sv
// Directed bench for qcontrol_delay_gain: a default-size instance for the
// main function and a 16-deep instance for pointer wrap at maximum delay.
module tb_qcontrol_delay_gain;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] tdata = '0;
   logic        tv_m = 1'b0;
   logic        tv_w = 1'b0;
   logic        en = 1'b0;
   logic [9:0]  delay = '0;
   logic [31:0] gain = '0;
   logic        use_w = 1'b0;

   logic signed [15:0] m_data;
   logic               m_valid;
   logic               m_sat;
   logic signed [15:0] w_data;
   logic               w_valid;
   logic               w_sat;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   int obs_data[$];
   bit obs_sat[$];
   int obs_cyc[$];
   int exp_data[$];
   bit exp_sat[$];
   int in_cyc[$];

   qcontrol_delay_gain dut (
      .a_clk(clk), .a_resetn(rst_n),
      .S_AXIS_SIGNAL_tdata(tdata), .S_AXIS_SIGNAL_tvalid(tv_m),
      .qc_enable(en), .qc_delay(delay), .qc_gain(gain),
      .M_AXIS_QS_tdata(m_data), .M_AXIS_QS_tvalid(m_valid), .qc_sat(m_sat)
   );

   qcontrol_delay_gain #(.DELAY_ADDR_WIDTH(4)) dut_w (
      .a_clk(clk), .a_resetn(rst_n),
      .S_AXIS_SIGNAL_tdata(tdata), .S_AXIS_SIGNAL_tvalid(tv_w),
      .qc_enable(en), .qc_delay(delay[3:0]), .qc_gain(gain),
      .M_AXIS_QS_tdata(w_data), .M_AXIS_QS_tvalid(w_valid), .qc_sat(w_sat)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: record every output strobe of either instance.
   always @(negedge clk) begin
      if (m_valid) begin
         obs_data.push_back(int'(m_data)); obs_sat.push_back(m_sat); obs_cyc.push_back(cyc);
      end
      if (w_valid) begin
         obs_data.push_back(int'(w_data)); obs_sat.push_back(w_sat); obs_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One input strobe with its hand-computed expected output.
   task automatic send(input int x, input int e, input bit es);
      tdata = {x[15:0], 16'hA5A5};
      if (use_w) tv_w = 1'b1; else tv_m = 1'b1;
      exp_data.push_back(e);
      exp_sat.push_back(es);
      in_cyc.push_back(cyc);
      @(negedge clk);
      tv_m = 1'b0;
      tv_w = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic score(input string tag);
      int idx = 0;
      check({tag, " count"}, obs_data.size(), exp_data.size());
      while (obs_data.size() > 0 && exp_data.size() > 0) begin
         int od, ed, oc, ic;
         bit os, es;
         od = obs_data.pop_front(); os = obs_sat.pop_front(); oc = obs_cyc.pop_front();
         ed = exp_data.pop_front(); es = exp_sat.pop_front(); ic = in_cyc.pop_front();
         $display("txn %s[%0d] data=%0d exp=%0d sat=%0b lat=%0d", tag, idx, od, ed, os, oc - ic);
         check($sformatf("%s[%0d] data", tag, idx), od, ed);
         check($sformatf("%s[%0d] sat", tag, idx), os, es);
         check($sformatf("%s[%0d] latency", tag, idx), oc - ic, 3);
         idx++;
      end
      obs_data.delete(); obs_sat.delete(); obs_cyc.delete();
      exp_data.delete(); exp_sat.delete(); in_cyc.delete();
   endtask

   initial begin
      // Reset state
      idle(3);
      check("rst data", m_data, 0);
      check("rst valid", m_valid, 0);
      check("rst sat", m_sat, 0);
      check("rst w data", w_data, 0);
      check("rst w valid", w_valid, 0);
      rst_n = 1'b1;
      idle(2);

      // Ramp with d=5, gain 1.0
      en = 1'b1; delay = 10'd5; gain = 32'h0040_0000;
      for (int n = 0; n < 20; n++) send(100 * n, (n < 5) ? 0 : 100 * (n - 5), 1'b0);
      idle(6);
      score("basic");

      // Saturation with gain 2.0, d=0
      delay = 10'd0; gain = 32'h0080_0000;
      send(30000, 32767, 1'b1);
      send(-30000, -32768, 1'b1);
      send(1000, 2000, 1'b0);
      idle(6);
      score("sat");

      // Rounding with gain 0.5, plus a negative gain
      gain = 32'h0020_0000;
      send(3, 2, 1'b0);
      send(-3, -1, 1'b0);
      send(1, 1, 1'b0);
      send(-1, 0, 1'b0);
      gain = 32'hFFC0_0000;
      send(1000, -1000, 1'b0);
      idle(6);
      score("round");

      // Enable toggle with d=8: disabled for samples 12..15
      en = 1'b0;
      idle(2);
      delay = 10'd8; gain = 32'h0040_0000;
      for (int k = 0; k < 40; k++) begin
         int e;
         en = !(k >= 12 && k < 16);
         if (!en) e = 0;
         else if (k < 8) e = 0;
         else if (k >= 16 && k < 24) e = 0;
         else e = 10 * (k - 8) + 7;
         send(10 * k + 7, e, 1'b0);
      end
      en = 1'b1;
      idle(6);
      score("enable");

      // 16-deep instance, d=15, gapped strobes across two pointer wraps
      use_w = 1'b1; delay = 10'd15;
      for (int n = 0; n < 40; n++) begin
         send(37 * n - 600, (n < 15) ? 0 : 37 * (n - 15) - 600, 1'b0);
         idle(2);
      end
      idle(6);
      score("wrap");
      use_w = 1'b0;

      // Asynchronous reset mid-stream with d=3
      en = 1'b0;
      idle(1);
      en = 1'b1; delay = 10'd3;
      for (int k = 0; k < 6; k++) send(500 + k, (k < 3) ? 0 : 500 + k - 3, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async rst data", m_data, 0);
      check("async rst valid", m_valid, 0);
      check("async rst sat", m_sat, 0);
      // The last two samples were still in the pipeline and must vanish.
      void'(exp_data.pop_back()); void'(exp_sat.pop_back()); void'(in_cyc.pop_back());
      void'(exp_data.pop_back()); void'(exp_sat.pop_back()); void'(in_cyc.pop_back());
      idle(5);
      rst_n = 1'b1;
      score("pre-reset");
      idle(2);
      for (int k = 0; k < 6; k++) send(-(200 + k), (k < 3) ? 0 : -(200 + k - 3), 1'b0);
      idle(6);
      score("post-reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
